// File: rtl/hpdcache_pkg.sv
// Shared types for the MSHR: entry state encoding, stored target record, index-width helper.
// No logic, so latency does not apply.
// No handshakes, so backpressure does not apply.
package hpdcache_pkg;

    typedef enum logic [1:0] {
        MSHR_FREE  = 2'd0,
        MSHR_PEND  = 2'd1,
        MSHR_DRAIN = 2'd2
    } mshr_state_e;

    // The target record has fixed field widths so one type serves every
    // instantiation. Each field is sized to the largest width the MSHR
    // accepts. Narrower requests are zero-extended on the way in and
    // truncated on the way out.
    localparam int unsigned MSHR_MAX_TID_W  = 16;
    localparam int unsigned MSHR_MAX_SID_W  = 8;
    localparam int unsigned MSHR_MAX_WORD_W = 8;
    localparam int unsigned MSHR_MAX_WAY_W  = 8;

    typedef struct packed {
        logic                       need_rsp;
        logic [MSHR_MAX_WAY_W-1:0]  way;
        logic [MSHR_MAX_WORD_W-1:0] word;
        logic [MSHR_MAX_SID_W-1:0]  sid;
        logic [MSHR_MAX_TID_W-1:0]  tid;
    } mshr_target_t;

    // Index width for n items. The result is never less than 1, so
    // single-item configurations still get a legal vector.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_mshr_mt_entry.sv
// One MSHR entry: the FREE/PEND/DRAIN state, the nline, and an in-order target FIFO.
// State and FIFO update on the clock edge that follows alloc/push/ack/pop; head_o is combinational from registers.
// The top only asserts push_i while count<Targets and pop_i while DRAIN, so the entry never stalls on its own.
module hpdcache_mshr_mt_entry
    import hpdcache_pkg::*;
#(
    parameter int unsigned Targets    = 4,
    parameter int unsigned NlineWidth = 26,
    localparam int unsigned PtrW      = idx_w(Targets),
    localparam int unsigned CntW      = idx_w(Targets + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_i,   // FREE -> PEND and store the first target
    input  logic                  push_i,    // append a merged target
    input  logic                  ack_i,     // PEND -> DRAIN
    input  logic                  pop_i,     // consume the head target
    input  logic [NlineWidth-1:0] nline_i,
    input  mshr_target_t          tgt_i,
    output mshr_state_e           state_o,
    output logic [NlineWidth-1:0] nline_o,
    output logic [CntW-1:0]       cnt_o,
    output mshr_target_t          head_o
);

    mshr_state_e           state_q;
    logic [CntW-1:0]       cnt_q;
    logic [PtrW-1:0]       rd_q, wr_q;
    logic [NlineWidth-1:0] nline_q;
    mshr_target_t          tgt_q [Targets];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Targets - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= MSHR_FREE;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else if (alloc_i) begin
            state_q <= MSHR_PEND;
            cnt_q   <= CntW'(1);
            rd_q    <= '0;
            wr_q    <= ptr_inc('0);
        end else begin
            // An ack and a merge may land together: the entry moves to DRAIN
            // and the merged target is still appended, so it gets drained.
            if (ack_i) state_q <= MSHR_DRAIN;
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i) begin
                rd_q <= ptr_inc(rd_q);
                if (cnt_q == CntW'(1)) state_q <= MSHR_FREE;
            end
            if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
            else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
        end
    end

    // The payload storage is never reset. A write while in reset is harmless,
    // because the entry comes out of reset FREE and its contents are ignored.
    always_ff @(posedge clk_i) begin
        if (alloc_i) begin
            nline_q   <= nline_i;
            tgt_q[0]  <= tgt_i;
        end else if (push_i) begin
            tgt_q[wr_q] <= tgt_i;
        end
    end

    assign state_o = state_q;
    assign nline_o = nline_q;
    assign cnt_o   = cnt_q;
    assign head_o  = tgt_q[rd_q];

endmodule

// File: rtl/hpdcache_mshr_mt.sv
// Fully-associative MSHR: merges secondary misses per line and drains targets in order after a refill ack.
// Alloc and ack decisions are combinational and take effect at the next edge; the first response comes 1 cycle after the ack.
// alloc_ready_o drops on a draining match, a full target list, or no free entry; ack_ready_o drops while draining; rsp holds until rsp_ready_i.
// Ports: alloc_* (request and target payload in; ready/merged/id out), ack_* (refill done),
//        rsp_* (drained targets, valid/ready), empty_o/full_o (entry occupancy).
module hpdcache_mshr_mt
    import hpdcache_pkg::*;
#(
    parameter int unsigned Entries    = 4,
    parameter int unsigned Targets    = 4,
    parameter int unsigned NlineWidth = 26,
    parameter int unsigned TidWidth   = 6,
    parameter int unsigned SidWidth   = 3,
    parameter int unsigned WordWidth  = 3,
    parameter int unsigned WayWidth   = 3,
    localparam int unsigned IdW       = idx_w(Entries),
    localparam int unsigned CntW      = idx_w(Targets + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_i,
    input  logic [NlineWidth-1:0] alloc_nline_i,
    input  logic [TidWidth-1:0]   alloc_tid_i,
    input  logic [SidWidth-1:0]   alloc_sid_i,
    input  logic [WordWidth-1:0]  alloc_word_i,
    input  logic [WayWidth-1:0]   alloc_way_i,
    input  logic                  alloc_need_rsp_i,
    output logic                  alloc_ready_o,
    output logic                  alloc_merged_o,
    output logic [IdW-1:0]        alloc_id_o,
    input  logic                  ack_i,
    input  logic [IdW-1:0]        ack_id_i,
    output logic                  ack_ready_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [NlineWidth-1:0] rsp_nline_o,
    output logic [TidWidth-1:0]   rsp_tid_o,
    output logic [SidWidth-1:0]   rsp_sid_o,
    output logic [WordWidth-1:0]  rsp_word_o,
    output logic [WayWidth-1:0]   rsp_way_o,
    output logic                  rsp_need_rsp_o,
    output logic                  rsp_last_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam logic [CntW-1:0] TgtMax = CntW'(Targets);

    mshr_state_e           ent_state [Entries];
    logic [NlineWidth-1:0] ent_nline [Entries];
    logic [CntW-1:0]       ent_cnt   [Entries];
    mshr_target_t          ent_head  [Entries];
    logic [Entries-1:0]    ent_alloc, ent_push, ent_ack, ent_pop;

    mshr_target_t   alloc_tgt, rsp_head;
    logic           hit, free_any, draining, merge_ok;
    logic [IdW-1:0] hit_id, free_id, drain_id;
    logic           unused_head;

    always_comb begin
        alloc_tgt = '0;
        alloc_tgt.tid[TidWidth-1:0]   = alloc_tid_i;
        alloc_tgt.sid[SidWidth-1:0]   = alloc_sid_i;
        alloc_tgt.word[WordWidth-1:0] = alloc_word_i;
        alloc_tgt.way[WayWidth-1:0]   = alloc_way_i;
        alloc_tgt.need_rsp            = alloc_need_rsp_i;
    end

    // The line match, the lowest-free-entry encoder and the draining-entry
    // search all read registered state. An entry freed at an edge therefore
    // cannot be handed out again until the following cycle.
    always_comb begin
        hit      = 1'b0;
        hit_id   = '0;
        free_any = 1'b0;
        free_id  = '0;
        draining = 1'b0;
        drain_id = '0;
        empty_o  = 1'b1;
        for (int i = Entries - 1; i >= 0; i--) begin
            if (ent_state[i] != MSHR_FREE) begin
                empty_o = 1'b0;
                if (ent_nline[i] == alloc_nline_i) begin
                    hit    = 1'b1;
                    hit_id = IdW'(i);
                end
            end else begin
                free_any = 1'b1;
                free_id  = IdW'(i);
            end
            if (ent_state[i] == MSHR_DRAIN) begin
                draining = 1'b1;
                drain_id = IdW'(i);
            end
        end
        full_o = !free_any;
    end

    assign merge_ok       = (ent_state[hit_id] == MSHR_PEND) && (ent_cnt[hit_id] < TgtMax);
    assign alloc_ready_o  = alloc_i && (hit ? merge_ok : free_any);
    assign alloc_merged_o = alloc_i && hit;
    assign alloc_id_o     = hit ? hit_id : free_id;

    // Only one entry drains at a time, which keeps the response mux a
    // single-source selection.
    assign ack_ready_o = !draining;

    assign rsp_valid_o    = draining;
    assign rsp_head       = ent_head[drain_id];
    assign rsp_nline_o    = ent_nline[drain_id];
    assign rsp_tid_o      = rsp_head.tid[TidWidth-1:0];
    assign rsp_sid_o      = rsp_head.sid[SidWidth-1:0];
    assign rsp_word_o     = rsp_head.word[WordWidth-1:0];
    assign rsp_way_o      = rsp_head.way[WayWidth-1:0];
    assign rsp_need_rsp_o = rsp_head.need_rsp;
    assign rsp_last_o     = (ent_cnt[drain_id] == CntW'(1));
    assign unused_head    = ^rsp_head;

    for (genvar g = 0; g < Entries; g++) begin : g_ent
        assign ent_alloc[g] = alloc_ready_o && !hit && (free_id == IdW'(g));
        assign ent_push[g]  = alloc_ready_o && hit && (hit_id == IdW'(g));
        assign ent_ack[g]   = ack_i && ack_ready_o && (ack_id_i == IdW'(g));
        assign ent_pop[g]   = rsp_valid_o && rsp_ready_i && (drain_id == IdW'(g));

        hpdcache_mshr_mt_entry #(
            .Targets    (Targets),
            .NlineWidth (NlineWidth)
        ) u_entry (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .alloc_i (ent_alloc[g]),
            .push_i  (ent_push[g]),
            .ack_i   (ent_ack[g]),
            .pop_i   (ent_pop[g]),
            .nline_i (alloc_nline_i),
            .tgt_i   (alloc_tgt),
            .state_o (ent_state[g]),
            .nline_o (ent_nline[g]),
            .cnt_o   (ent_cnt[g]),
            .head_o  (ent_head[g])
        );
    end

    // A refill ack is only meaningful for an entry that is waiting on one.
    a_ack_to_pend: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ack_i && ack_ready_o) |-> (ent_state[ack_id_i] == MSHR_PEND));

endmodule

// File: tb/tb_hpdcache_mshr_mt.sv
module tb_hpdcache_mshr_mt;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        alloc;
    logic [25:0] alloc_nline;
    logic [5:0]  alloc_tid;
    logic [2:0]  alloc_sid, alloc_word, alloc_way;
    logic        alloc_need_rsp;
    logic        alloc_ready, alloc_merged;
    logic [1:0]  alloc_id;
    logic        ack;
    logic [1:0]  ack_id;
    logic        ack_ready;
    logic        rsp_valid, rsp_ready;
    logic [25:0] rsp_nline;
    logic [5:0]  rsp_tid;
    logic [2:0]  rsp_sid, rsp_word, rsp_way;
    logic        rsp_need_rsp, rsp_last;
    logic        empty, full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hpdcache_mshr_mt dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .alloc_i          (alloc),
        .alloc_nline_i    (alloc_nline),
        .alloc_tid_i      (alloc_tid),
        .alloc_sid_i      (alloc_sid),
        .alloc_word_i     (alloc_word),
        .alloc_way_i      (alloc_way),
        .alloc_need_rsp_i (alloc_need_rsp),
        .alloc_ready_o    (alloc_ready),
        .alloc_merged_o   (alloc_merged),
        .alloc_id_o       (alloc_id),
        .ack_i            (ack),
        .ack_id_i         (ack_id),
        .ack_ready_o      (ack_ready),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_nline_o      (rsp_nline),
        .rsp_tid_o        (rsp_tid),
        .rsp_sid_o        (rsp_sid),
        .rsp_word_o       (rsp_word),
        .rsp_way_o        (rsp_way),
        .rsp_need_rsp_o   (rsp_need_rsp),
        .rsp_last_o       (rsp_last),
        .empty_o          (empty),
        .full_o           (full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Payload fields are derived from the tid so the expected response can be rebuilt from it.
    task automatic drive_alloc(input logic [25:0] n, input logic [5:0] t);
        alloc          = 1'b1;
        alloc_nline    = n;
        alloc_tid      = t;
        alloc_sid      = t[2:0];
        alloc_word     = ~t[2:0];
        alloc_way      = t[2:0] + 3'd1;
        alloc_need_rsp = t[0];
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; alloc = 1'b0; ack = 1'b0; ack_id = '0; rsp_ready = 1'b0;
        drive_alloc(26'h0, 6'd0);
        alloc = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (ack_ready !== 1'b1) begin bad++; $display("FAIL reset_ack_ready got=%b exp=1", ack_ready); end
    endtask

    task automatic test_alloc_merge();
        logic [5:0] t;
        do_reset();
        drive_alloc(26'h100, 6'd1); #1;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL first_ready got=%b exp=1", alloc_ready); end
        total++; if (alloc_merged !== 1'b0) begin bad++; $display("FAIL first_merged got=%b exp=0", alloc_merged); end
        total++; if (alloc_id !== 2'd0) begin bad++; $display("FAIL first_id got=%0d exp=0", alloc_id); end
        tick();
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL empty_after_alloc got=%b exp=0", empty); end
        for (int k = 2; k <= 3; k++) begin
            drive_alloc(26'h100, 6'(k)); #1;
            total++; if ({alloc_ready, alloc_merged, alloc_id} !== 4'b1100) begin
                bad++; $display("FAIL merge_%0d got rdy/mrg/id=%b%b%0d exp=110", k, alloc_ready, alloc_merged, alloc_id); end
            tick();
        end
        alloc = 1'b0; ack = 1'b1; ack_id = 2'd0; #1;
        total++; if (ack_ready !== 1'b1) begin bad++; $display("FAIL ack_ready_pend got=%b exp=1", ack_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_before_ack got=%b exp=0", rsp_valid); end
        tick();
        ack = 1'b0; rsp_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            t = 6'(k); #1;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL drain_valid_%0d got=%b exp=1", k, rsp_valid); end
            total++; if (rsp_tid !== t) begin bad++; $display("FAIL drain_tid_%0d got=%0d exp=%0d", k, rsp_tid, t); end
            total++; if (rsp_last !== (k == 3)) begin bad++; $display("FAIL drain_last_%0d got=%b exp=%b", k, rsp_last, (k == 3)); end
            total++; if ({rsp_nline, rsp_sid, rsp_word, rsp_way, rsp_need_rsp} !== {26'h100, t[2:0], ~t[2:0], t[2:0] + 3'd1, t[0]}) begin
                bad++; $display("FAIL drain_payload_%0d got=%h/%0d/%0d/%0d/%b", k, rsp_nline, rsp_sid, rsp_word, rsp_way, rsp_need_rsp); end
            tick();
        end
        rsp_ready = 1'b0; #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL after_drain_valid got=%b exp=0", rsp_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL after_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full();
        logic [5:0] exp_t [4] = '{6'd2, 6'd10, 6'd11, 6'd12};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_alloc(26'h200 + 26'(i), 6'(i)); #1;
            total++; if ({alloc_ready, alloc_merged, alloc_id} !== {2'b10, 2'(i)}) begin
                bad++; $display("FAIL fill_%0d got rdy/mrg/id=%b%b%0d exp=10%0d", i, alloc_ready, alloc_merged, alloc_id, i); end
            tick();
        end
        alloc = 1'b0; #1;
        total++; if ({full, empty} !== 2'b10) begin bad++; $display("FAIL full_flags got full/empty=%b%b exp=10", full, empty); end
        drive_alloc(26'h204, 6'd9); #1;
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fifth_distinct got=%b exp=0", alloc_ready); end
        for (int k = 0; k < 3; k++) begin
            drive_alloc(26'h202, 6'(10 + k)); #1;
            total++; if ({alloc_ready, alloc_id} !== 3'b110) begin
                bad++; $display("FAIL merge_full_%0d got rdy/id=%b%0d exp=12", k, alloc_ready, alloc_id); end
            tick();
        end
        drive_alloc(26'h202, 6'd13); #1;
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL targets_full got=%b exp=0", alloc_ready); end
        tick();
        alloc = 1'b0; ack = 1'b1; ack_id = 2'd2; tick();
        ack = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if ({rsp_valid, rsp_tid, rsp_last} !== {1'b1, exp_t[k], (k == 3)}) begin
                bad++; $display("FAIL full_drain_%0d got v/tid/last=%b/%0d/%b exp=1/%0d/%b", k, rsp_valid, rsp_tid, rsp_last, exp_t[k], (k == 3)); end
            tick();
        end
        rsp_ready = 1'b0; #1;
        total++; if ({rsp_valid, full} !== 2'b00) begin bad++; $display("FAIL full_drain_end got v/full=%b%b exp=00", rsp_valid, full); end
    endtask

    task automatic test_stall();
        int pat [5] = '{1, 0, 0, 1, 1};
        logic [5:0] exp_t [3] = '{6'd5, 6'd6, 6'd7};
        int idx = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin drive_alloc(26'h300, 6'(5 + k)); tick(); end
        alloc = 1'b0; ack = 1'b1; ack_id = 2'd0; tick();
        ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rsp_ready = pat[c][0]; #1;
            total++; if ({rsp_valid, rsp_tid, ack_ready} !== {1'b1, exp_t[idx], 1'b0}) begin
                bad++; $display("FAIL stall_%0d got v/tid/ackrdy=%b/%0d/%b exp=1/%0d/0", c, rsp_valid, rsp_tid, ack_ready, exp_t[idx]); end
            if (pat[c] == 1) idx++;
            tick();
        end
        rsp_ready = 1'b0; #1;
        total++; if ({rsp_valid, empty} !== 2'b01) begin bad++; $display("FAIL stall_end got v/empty=%b%b exp=01", rsp_valid, empty); end
    endtask

    task automatic test_drain_realloc();
        do_reset();
        drive_alloc(26'h400, 6'd9); tick();
        alloc = 1'b0; ack = 1'b1; ack_id = 2'd0; tick();
        ack = 1'b0; drive_alloc(26'h400, 6'd20); #1;
        total++; if ({alloc_ready, rsp_valid, ack_ready} !== 3'b010) begin
            bad++; $display("FAIL alloc_during_drain got rdy/v/ackrdy=%b%b%b exp=010", alloc_ready, rsp_valid, ack_ready); end
        tick();
        rsp_ready = 1'b1; #1;
        total++; if ({alloc_ready, rsp_last} !== 2'b01) begin bad++; $display("FAIL alloc_at_last_pop got rdy/last=%b%b exp=01", alloc_ready, rsp_last); end
        tick();
        rsp_ready = 1'b0; #1;
        total++; if ({rsp_valid, alloc_ready, alloc_merged, alloc_id} !== 5'b01000) begin
            bad++; $display("FAIL realloc got v/rdy/mrg/id=%b%b%b%0d exp=0100", rsp_valid, alloc_ready, alloc_merged, alloc_id); end
        tick();
        alloc = 1'b0; #1;
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL realloc_empty got=%b exp=0", empty); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive_alloc(26'h500, 6'd1); tick();
        drive_alloc(26'h500, 6'd2); ack = 1'b1; ack_id = 2'd0; #1;
        total++; if ({alloc_ready, alloc_merged, ack_ready, rsp_valid} !== 4'b1110) begin
            bad++; $display("FAIL same_cycle got rdy/mrg/ackrdy/v=%b%b%b%b exp=1110", alloc_ready, alloc_merged, ack_ready, rsp_valid); end
        tick();
        alloc = 1'b0; ack = 1'b0; rsp_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            #1;
            total++; if ({rsp_valid, rsp_tid, rsp_last} !== {1'b1, 6'(k), (k == 2)}) begin
                bad++; $display("FAIL same_cycle_drain_%0d got v/tid/last=%b/%0d/%b", k, rsp_valid, rsp_tid, rsp_last); end
            tick();
        end
        rsp_ready = 1'b0; #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_end got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drive_alloc(26'h600, 6'd1); tick();
        drive_alloc(26'h600, 6'd2); tick();
        drive_alloc(26'h601, 6'd3); tick();
        alloc = 1'b0; ack = 1'b1; ack_id = 2'd0; tick();
        ack = 1'b0; rsp_ready = 1'b1; #1;
        total++; if (rsp_tid !== 6'd1) begin bad++; $display("FAIL mid_drain_first got=%0d exp=1", rsp_tid); end
        tick();
        rst_ni = 1'b0; tick();
        total++; if ({rsp_valid, empty, full} !== 3'b010) begin
            bad++; $display("FAIL mid_drain_reset got v/empty/full=%b%b%b exp=010", rsp_valid, empty, full); end
        rst_ni = 1'b1; tick(); tick();
        total++; if ({rsp_valid, empty} !== 2'b01) begin bad++; $display("FAIL post_reset got v/empty=%b%b exp=01", rsp_valid, empty); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alloc_merge();
        test_full();
        test_stall();
        test_drain_realloc();
        test_same_cycle();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpdcache_mshr_mt.md
HPDCACHE_MSHR_MT -- requirements
Module: hpdcache_mshr_mt

Interface
REQ-001 SHALL have parameter Entries, default 4, meaning number of fully-associative MSHR entries (>=1).
REQ-002 SHALL have parameter Targets, default 4, meaning maximum merged requests per entry (>=1).
REQ-003 SHALL have parameter NlineWidth, default 26, meaning cache-line address width.
REQ-004 SHALL have parameter TidWidth, default 6, meaning request transaction-ID width.
REQ-005 SHALL have parameter SidWidth, default 3, meaning request source-ID width.
REQ-006 SHALL have parameter WordWidth, default 3, meaning word-index width.
REQ-007 SHALL have parameter WayWidth, default 3, meaning victim-way index width.
REQ-008 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst_ni  in  1  reset, synchronous and active-low.
REQ-010 SHALL have ports alloc_i in 1, alloc_nline_i in NlineWidth, alloc_tid_i in TidWidth, alloc_sid_i in SidWidth, alloc_word_i in WordWidth, alloc_way_i in WayWidth, alloc_need_rsp_i in 1: allocation request and target payload.
REQ-011 SHALL have ports alloc_ready_o out 1, alloc_merged_o out 1, alloc_id_o out clog2(Entries): accept, secondary-miss merge, and entry index.
REQ-012 SHALL have ports ack_i in 1, ack_id_i in clog2(Entries), ack_ready_o out 1: refill-complete notification.
REQ-013 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_nline_o, rsp_tid_o, rsp_sid_o, rsp_word_o, rsp_way_o, rsp_need_rsp_o, rsp_last_o out: drained targets.
REQ-014 SHALL have ports empty_o out 1, full_o out 1: no entry in use / every entry in use.

Function
REQ-015 Each entry SHALL be in one of FREE, PEND, or DRAIN, and SHALL hold an nline, a target FIFO of depth Targets, and a count of 0..Targets.
REQ-016 Alloc SHALL match alloc_nline_i combinationally against all PEND and DRAIN entries; at most one entry SHALL match.
REQ-017 If alloc_i, the matching entry is PEND, and count<Targets: alloc_ready_o=1, alloc_merged_o=1, alloc_id_o=match index, and the target is appended at the next edge.
REQ-018 If alloc_i and no entry matches, with a FREE entry available: alloc_ready_o=1, alloc_merged_o=0, alloc_id_o=lowest FREE index, and that entry becomes PEND with count=1 at the next edge.
REQ-019 alloc_ready_o SHALL be 0, with no state change, when the match is DRAIN, the match is PEND with count==Targets, or there is no match and no FREE entry.
REQ-020 ack_ready_o SHALL be 1 only when no entry is in DRAIN; ack_i&&ack_ready_o SHALL move PEND entry ack_id_i to DRAIN at the next edge; ack to a non-PEND entry is illegal and asserted against.
REQ-021 While an entry is in DRAIN, rsp_valid_o=1 and rsp_* SHALL present the oldest remaining target in allocation order; rsp_last_o=1 when count==1.
REQ-022 Each cycle with rsp_valid_o&&rsp_ready_i SHALL pop one target; popping the last target SHALL make the entry FREE at the same edge; the first rsp_valid_o SHALL appear the cycle after ack acceptance.
REQ-023 An entry freed at edge N SHALL NOT be reallocated before edge N+1 (FREE status is registered).
REQ-024 A same-cycle alloc and ack to the same entry SHALL let the ack take effect and the merge append; the appended target SHALL be drained.
REQ-025 empty_o and full_o SHALL be computed combinationally from registered entry states; with Entries==1 or Targets==1 behaviour SHALL be unchanged apart from degenerate widths (minimum width 1).

Reset
REQ-026 On rst_ni==0 at a clock edge, all entries SHALL go FREE with count 0, drain pointers 0, rsp_valid_o=0, and empty_o=1, full_o=0.
REQ-027 Reset mid-drain SHALL discard all remaining targets, with no further rsp_valid_o.
REQ-028 Stored nline and target payloads SHALL need no reset.

Structure
REQ-029 The entry-state enum, the target struct type, and a clog2-based index-width helper SHALL live in hpdcache_pkg.
REQ-030 One sub-module hpdcache_mshr_mt_entry SHALL implement the state, nline, and target FIFO of one entry, instantiated Entries times; the top SHALL contain the match logic, the free-slot priority encoder, and the drain mux.

Verification
REQ-031 Reset, then alloc nline 0x100 tid 1 -> alloc_ready_o=1, merged=0, id=0; next cycle empty_o=0.
REQ-032 Alloc 0x100 tid 2, then tid 3 -> merged=1, id=0; ack id 0 -> three responses tids 1,2,3 in order, rsp_last_o only on tid 3; entry FREE afterwards; empty_o=1.
REQ-033 Default parameters, fill 4 distinct nlines -> full_o=1; fifth distinct alloc -> alloc_ready_o=0; a fifth Targets merge to one entry -> alloc_ready_o=0.
REQ-034 Drain with rsp_ready_i toggled 1,0,0,1 -> each target is held stable while stalled, with no loss or duplication; ack_ready_o=0 throughout the drain.
REQ-035 Alloc the same nline during DRAIN -> alloc_ready_o=0; after the last pop, re-alloc the same nline is accepted one cycle later as a new entry.
REQ-036 Assert rst_ni low mid-drain -> rsp_valid_o=0 the next cycle, all entries FREE.
